step_pattern_sequencer: RTL

Pattern store and step sequencer feeding the tone generator's 12-bit `Select` input. Holds a programmable STEPS×TONES on/off grid, advances one column per `Step` pulse from the BPM counter, repeats the pattern `Loops` times, then stops. Drives `Select`, `Play` and a per-step strobe for the audio path, replacing the free-standing loop counter with pattern-aware playback.

---
 rtl/step_pattern_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/step_pattern_sequencer.sv
// Programmable STEPS x TONES on/off grid played one column per Step pulse,
// repeated Loops times, driving the tone generator's Select mask.
module step_pattern_sequencer #(
  parameter int STEPS = 16,
  parameter int TONES = 12,
  parameter int SW    = $clog2(STEPS)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             nStart,
  input  logic             Step,
  input  logic [7:0]       Loops,
  input  logic             WrEn,
  input  logic [SW-1:0]    WrAddr,
  input  logic [TONES-1:0] WrData,
  output logic [TONES-1:0] Select,
  output logic [SW-1:0]    StepIdx,
  output logic             StepStrobe,
  output logic             Play,
  output logic             Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [SW-1:0] LAST_IDX = SW'(STEPS - 1);

  state_t           state, state_next;
  logic [TONES-1:0] mem [STEPS];
  logic [SW-1:0]    idx, idx_next;
  logic [7:0]       loop_cnt, loop_next;
  logic [TONES-1:0] select_q, select_next;
  logic             strobe_q, strobe_next;
  logic             nstart_q;
  logic             armed;
  logic             start;
  logic             last_loop;

  // A start needs nStart to have been seen high since reset, so a start
  // button held down through a reset cannot immediately relaunch playback.
  assign start     = armed & nstart_q & ~nStart;
  assign last_loop = (loop_cnt == (Loops - 8'd1));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      nstart_q <= 1'b1;
      armed    <= 1'b0;
    end else begin
      nstart_q <= nStart;
      armed    <= armed | nStart;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < STEPS; i++) mem[i] <= '0;
    end else if (WrEn) begin
      mem[WrAddr] <= WrData;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      idx      <= '0;
      loop_cnt <= '0;
      select_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      loop_cnt <= loop_next;
      select_q <= select_next;
      strobe_q <= strobe_next;
    end
  end

  // Start wins over a coincident Step; the last Step of the last loop ends the run.
  always_comb begin
    state_next  = state;
    idx_next    = idx;
    loop_next   = loop_cnt;
    strobe_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          idx_next  = '0;
          loop_next = '0;
          if (Loops != 8'd0) begin
            state_next  = PLAY;
            strobe_next = 1'b1;
          end else begin
            state_next = DONE;
          end
        end
      end
      PLAY: begin
        if (start) begin
          idx_next    = '0;
          loop_next   = '0;
          strobe_next = 1'b1;
        end else if (Step) begin
          if (idx != LAST_IDX) begin
            idx_next    = idx + 1'b1;
            strobe_next = 1'b1;
          end else if (!last_loop) begin
            idx_next    = '0;
            loop_next   = loop_cnt + 8'd1;
            strobe_next = 1'b1;
          end else begin
            state_next = DONE;
            idx_next   = '0;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        idx_next   = '0;
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // Reading the memory every cycle lets a write to the playing column reach
  // Select one cycle after the write edge.
  always_comb begin
    select_next = '0;
    if (state_next == PLAY) select_next = mem[idx_next];
  end

  assign Select     = select_q;
  assign StepIdx    = idx;
  assign StepStrobe = strobe_q;
  assign Play       = (state == PLAY);
  assign Done       = (state == DONE);

endmodule
